bcd_seg7_scan_driver: RTL and testbench

Parametrised multi-digit successor to the single-digit BCD-to-7-segment decoder. Captures NUM_DIGITS packed BCD digits into a shadow register and time-multiplexes them onto one shared segment bus with a one-hot digit select, paced by an internal prescaler. Adds leading-zero blanking, a per-digit decimal point, invalid-code handling, selectable output polarity and a frame-done strobe. Sits between the counter/datapath logic and the board display pins.

---
 rtl/bcd_seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_bcd_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg7_scan_driver.sv
// Multiplexed multi-digit BCD to 7-segment driver: shadow-captured digits scanned
// onto one segment bus with one-hot digit select, blanking and polarity control.

module bcd_seg7_digit (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000001;
        if (blank) begin
            seg = 7'b0000000;
        end else begin
            case (bcd)
                4'd0:    seg = 7'b1111110;
                4'd1:    seg = 7'b0110000;
                4'd2:    seg = 7'b1101101;
                4'd3:    seg = 7'b1111001;
                4'd4:    seg = 7'b0110011;
                4'd5:    seg = 7'b1011011;
                4'd6:    seg = 7'b1011111;
                4'd7:    seg = 7'b1110000;
                4'd8:    seg = 7'b1111111;
                4'd9:    seg = 7'b1111011;
                default: seg = 7'b0000001;
            endcase
        end
    end
endmodule

module bcd_seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);
    localparam int   IW  = $clog2(NUM_DIGITS);
    localparam int   CW  = $clog2(PRESCALE);
    localparam logic POL = (COMMON_ANODE != 0);

    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0]      shadow_dp;
    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;

    logic [NUM_DIGITS:0]        zero_from;
    logic [NUM_DIGITS-1:0]      blank_vec;
    logic [NUM_DIGITS-1:0]      invalid;
    logic [NUM_DIGITS-1:0][6:0] dec;
    logic [NUM_DIGITS-1:0]      sel_oh;
    logic                       last_cnt;
    logic                       last_idx;

    // zero_from[i]: digit i and every digit above it hold exactly zero
    assign zero_from[NUM_DIGITS] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign zero_from[g] = (shadow[g] == 4'd0) && zero_from[g+1];
        assign blank_vec[g] = (g == 0) ? 1'b0 : (blank_lz && zero_from[g]);
        assign invalid[g]   = (shadow[g] > 4'd9);
        bcd_seg7_digit u_dig (
            .bcd   (shadow[g]),
            .blank (blank_vec[g]),
            .seg   (dec[g])
        );
    end

    assign last_cnt = (cnt == CW'(PRESCALE - 1));
    assign last_idx = (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        sel_oh = '0;
        sel_oh[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            shadow_dp  <= '0;
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            seg        <= {7{POL}};
            dp         <= POL;
            an         <= {NUM_DIGITS{POL}};
        end else begin
            if (load) begin
                shadow    <= bcd_in;
                shadow_dp <= dp_in;
            end
            err        <= |invalid;
            frame_done <= 1'b0;
            if (enable) begin
                // outputs follow the pre-edge index/shadow, giving one clock of lag
                seg <= dec[idx] ^ {7{POL}};
                dp  <= shadow_dp[idx] ^ POL;
                an  <= sel_oh ^ {NUM_DIGITS{POL}};
                if (last_cnt) begin
                    cnt        <= '0;
                    idx        <= last_idx ? '0 : idx + IW'(1);
                    frame_done <= last_idx;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                seg <= {7{POL}};
                dp  <= POL;
                an  <= {NUM_DIGITS{POL}};
            end
        end
    end
endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Scoreboard bench: a common-cathode and a common-anode instance share stimulus;
// expectations are queued by cycle and checked by an independent negedge monitor.

module tb_bcd_seg7_scan_driver;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;
    logic        err0, err1;

    bcd_seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0),
        .frame_done(fd0), .err(err0)
    );
    bcd_seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1),
        .frame_done(fd1), .err(err1)
    );

    // field mask bits: 0=an 1=seg 2=dp 3=frame_done 4=err
    typedef struct {
        int         cyc;
        logic [4:0] m;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       err;
        int         ph;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [6:0] SEG [0:10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b0000001};
    string PH [0:6] = '{"reset_scan", "decode", "invalid", "lead_zero",
                        "enable", "async_rst", "clear_err"};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input int ph, input int c, input string f,
                       input logic [6:0] got, input logic [6:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc%0d %s: got %b want %b", PH[ph], c, f, got, want);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            if (me.cyc < cyc) begin
                n_chk++;
                $display("FAIL %s cyc%0d missed check at cyc%0d", PH[me.ph], me.cyc, cyc);
            end else begin
                if (me.m[0]) begin
                    cmp(me.ph, me.cyc, "an_cc", {3'b0, an0}, {3'b0, me.an});
                    cmp(me.ph, me.cyc, "an_ca", {3'b0, an1}, {3'b0, ~me.an});
                end
                if (me.m[1]) begin
                    cmp(me.ph, me.cyc, "seg_cc", seg0, me.seg);
                    cmp(me.ph, me.cyc, "seg_ca", seg1, ~me.seg);
                end
                if (me.m[2]) begin
                    cmp(me.ph, me.cyc, "dp_cc", {6'b0, dp0}, {6'b0, me.dp});
                    cmp(me.ph, me.cyc, "dp_ca", {6'b0, dp1}, {6'b0, ~me.dp});
                end
                if (me.m[3]) begin
                    cmp(me.ph, me.cyc, "fd_cc", {6'b0, fd0}, {6'b0, me.fd});
                    cmp(me.ph, me.cyc, "fd_ca", {6'b0, fd1}, {6'b0, me.fd});
                end
                if (me.m[4]) begin
                    cmp(me.ph, me.cyc, "err_cc", {6'b0, err0}, {6'b0, me.err});
                    cmp(me.ph, me.cyc, "err_ca", {6'b0, err1}, {6'b0, me.err});
                end
            end
        end
    end

    task automatic push(input int c, input logic [4:0] m, input logic [3:0] a,
                        input logic [6:0] s, input logic d, input logic f,
                        input logic e, input int ph);
        exp_t x;
        int   i;
        x.cyc = c; x.m = m; x.an = a; x.seg = s; x.dp = d; x.fd = f; x.err = e; x.ph = ph;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reset, release with a load on the first edge; base = cycle of that first edge
    task automatic restart(input logic [15:0] b, input logic [3:0] d, input logic z,
                           output int base);
        rst = 1'b1;
        step(1);
        rst = 1'b0; enable = 1'b1; load = 1'b1; bcd_in = b; dp_in = d; blank_lz = z;
        step(1);
        load = 1'b0;
        base = cyc;
    endtask

    // one sample per digit, mid-slot; digit d is shown at base+4d..base+4d+3
    task automatic chk_digits(input int base, input logic [3:0][6:0] s,
                              input logic [3:0] dps, input int ph);
        for (int d = 0; d < 4; d++)
            push(base + 4*d + 2, 5'b00111, 4'b0001 << d, s[d], dps[d], 1'b0, 1'b0, ph);
    endtask

    initial begin
        int base;
        logic [3:0] v;
        rst = 1'b1; enable = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;

        // reset state and scan pacing
        step(2);
        push(cyc, 5'b11111, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        base = cyc + 1;
        for (int j = 0; j <= 16; j++)
            push(base + j, 5'b01111, 4'b0001 << ((j / 4) % 4), SEG[0], 1'b0, (j == 15), 1'b0, 0);
        step(18);

        // decode sweep 0x0000..0x9999
        for (int k = 0; k <= 9; k++) begin
            v = 4'(k);
            restart({v, v, v, v}, 4'b0000, 1'b0, base);
            chk_digits(base, {SEG[k], SEG[k], SEG[k], SEG[k]}, 4'b0000, 1);
            push(base + 1, 5'b10000, 4'b0, 7'b0, 1'b0, 1'b0, 1'b0, 1);
            step(16);
        end

        // invalid code, err timing, then cleared by a valid load
        restart(16'h12A4, 4'b0000, 1'b0, base);
        push(base, 5'b10000, 4'b0, 7'b0, 1'b0, 1'b0, 1'b0, 2);
        push(base + 1, 5'b10000, 4'b0, 7'b0, 1'b0, 1'b0, 1'b1, 2);
        chk_digits(base, {7'b0110000, 7'b1101101, 7'b0000001, 7'b0110011}, 4'b0000, 2);
        step(16);
        load = 1'b1; bcd_in = 16'h1234;
        step(1);
        load = 1'b0;
        push(cyc, 5'b10000, 4'b0, 7'b0, 1'b0, 1'b0, 1'b1, 6);
        push(cyc + 1, 5'b10000, 4'b0, 7'b0, 1'b0, 1'b0, 1'b0, 6);
        step(2);

        // leading-zero blanking
        restart(16'h0050, 4'b1000, 1'b1, base);
        chk_digits(base, {7'b0000000, 7'b0000000, SEG[5], SEG[0]}, 4'b1000, 3);
        step(16);
        restart(16'h0000, 4'b0000, 1'b1, base);
        chk_digits(base, {7'b0000000, 7'b0000000, 7'b0000000, SEG[0]}, 4'b0000, 3);
        step(16);
        restart(16'h0A00, 4'b0000, 1'b1, base);
        chk_digits(base, {7'b0000000, SEG[10], SEG[0], SEG[0]}, 4'b0000, 3);
        step(16);

        // enable drop mid digit 2, resume with remaining count
        restart(16'h8888, 4'b0000, 1'b0, base);
        push(base + 8, 5'b00111, 4'b0100, SEG[8], 1'b0, 1'b0, 1'b0, 4);
        step(9);
        enable = 1'b0;
        for (int j = 10; j <= 12; j++)
            push(base + j, 5'b01111, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, 4);
        step(3);
        enable = 1'b1;
        push(base + 13, 5'b00111, 4'b0100, SEG[8], 1'b0, 1'b0, 1'b0, 4);
        push(base + 14, 5'b00011, 4'b0100, SEG[8], 1'b0, 1'b0, 1'b0, 4);
        push(base + 15, 5'b00011, 4'b1000, SEG[8], 1'b0, 1'b0, 1'b0, 4);
        push(base + 17, 5'b01001, 4'b1000, 7'b0, 1'b0, 1'b0, 1'b0, 4);
        push(base + 18, 5'b01001, 4'b1000, 7'b0, 1'b0, 1'b1, 1'b0, 4);
        push(base + 19, 5'b01001, 4'b0001, 7'b0, 1'b0, 1'b0, 1'b0, 4);
        step(8);

        // async reset between edges while digit 2 is shown
        restart(16'h8888, 4'b0000, 1'b0, base);
        push(base + 8, 5'b00011, 4'b0100, SEG[8], 1'b0, 1'b0, 1'b0, 5);
        step(9);
        #2;
        rst = 1'b1;
        push(base + 9, 5'b01111, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, 5);
        step(1);
        push(base + 10, 5'b01111, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, 5);
        rst = 1'b0;
        push(base + 11, 5'b00011, 4'b0001, SEG[0], 1'b0, 1'b0, 1'b0, 5);
        push(base + 14, 5'b00011, 4'b0001, SEG[0], 1'b0, 1'b0, 1'b0, 5);
        push(base + 15, 5'b00011, 4'b0010, SEG[0], 1'b0, 1'b0, 1'b0, 5);
        step(6);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            me = sb.pop_front();
            n_chk++;
            $display("FAIL %s cyc%0d check never reached", PH[me.ph], me.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
